// File: rtl/ones_count_stream_pkg.sv
// Shared definitions for the streaming ones counter: FSM state encodings and
// the count-width helper used to size COUNT from the word width.
package ones_count_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits needed to hold any value 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ones_count_stream_chunk_popcount.sv
// Combinational popcount of one CHUNK-bit slice; the top feeds it the low
// bits of its shift register once per BUSY cycle.
module chunk_popcount #(
    parameter int  CHUNK = 4,
    localparam int PC_W  = $clog2(CHUNK + 1)
) (
    input  logic [CHUNK-1:0] bits,
    output logic [PC_W-1:0]  ones
);

    always_comb begin
        ones = '0;
        for (int i = 0; i < CHUNK; i++) begin
            ones = ones + PC_W'(bits[i]);
        end
    end

endmodule

// File: rtl/ones_count_stream.sv
// Multi-cycle streaming population counter with a saturating running total.
// Build option ONES_COUNT_EARLY_EN: finish as soon as the remaining bits are all zero.
//
// state | meaning
// IDLE  | ready for a word (in_ready high)
// BUSY  | counting one CHUNK slice per cycle
// DONE  | count presented (out_valid high) until out_ready
module ones_count_stream
    import ones_count_stream_pkg::*;
#(
    parameter int  WIDTH = 16,
    parameter int  CHUNK = 4,
    parameter int  ACC_W = 16,
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count,
    output logic [ACC_W-1:0] total,
    input  logic             clr_total,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = cnt_width(NCHUNK);
    localparam int PC_W   = $clog2(CHUNK + 1);
    localparam int SUM_W  = ((ACC_W > CNT_W) ? ACC_W : CNT_W) + 1;
    localparam logic [SUM_W-1:0] TOTAL_MAX = SUM_W'({ACC_W{1'b1}});

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_post;
    logic [CNT_W-1:0] count_q, count_sum;
    logic [IDX_W-1:0] idx_q;
    logic [ACC_W-1:0] total_q, total_base;
    logic [PC_W-1:0]  chunk_ones;
    logic [SUM_W-1:0] total_sum;
    logic             last_chunk, done_entry;

    chunk_popcount #(.CHUNK(CHUNK)) u_chunk_popcount (
        .bits (shift_q[CHUNK-1:0]),
        .ones (chunk_ones)
    );

    assign shift_post = shift_q >> CHUNK;
    assign count_sum  = count_q + CNT_W'(chunk_ones);

`ifdef ONES_COUNT_EARLY_EN
    assign last_chunk = (idx_q == IDX_W'(NCHUNK - 1)) || (shift_post == '0);
`else
    assign last_chunk = (idx_q == IDX_W'(NCHUNK - 1));
`endif

    // Clear wins over the old total but the finishing word is still added.
    assign total_base = clr_total ? '0 : total_q;
    assign total_sum  = SUM_W'(total_base) + SUM_W'(count_sum);

    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        done_entry = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = rst_n;
                if (in_valid) state_d = ST_BUSY;
            end
            ST_BUSY: begin
                busy = 1'b1;
                if (last_chunk) begin
                    state_d    = ST_DONE;
                    done_entry = 1'b1;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            count_q <= '0;
            idx_q   <= '0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && in_valid) begin
                shift_q <= data;
                count_q <= '0;
                idx_q   <= '0;
            end else if (state_q == ST_BUSY) begin
                shift_q <= shift_post;
                count_q <= count_sum;
                idx_q   <= idx_q + IDX_W'(1);
            end
            if (done_entry) begin
                total_q <= (total_sum > TOTAL_MAX) ? ACC_W'(TOTAL_MAX) : total_sum[ACC_W-1:0];
            end else if (clr_total) begin
                total_q <= '0;
            end
        end
    end

    assign count = count_q;
    assign total = total_q;

endmodule

// File: tb/tb_ones_count_stream.sv
// Randomized self-checking bench for ones_count_stream against a word-level model.
module tb_ones_count_stream;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int ACC_W  = 16;
    localparam int CNT_W  = 5;
    localparam int TOT_MAX = (1 << ACC_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready, out_valid, out_ready, clr_total, busy;
    logic [WIDTH-1:0] data;
    logic [CNT_W-1:0] count;
    logic [ACC_W-1:0] total;

    logic             s_in_valid, s_in_ready, s_out_valid, s_busy;
    logic [WIDTH-1:0] s_data;
    logic [CNT_W-1:0] s_count;
    logic [4:0]       s_total;

    int n_total = 0;
    int n_bad   = 0;
    int ref_total = 0;

    always #5 clk = ~clk;

    ones_count_stream #(.WIDTH(WIDTH), .CHUNK(CHUNK), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data      (data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .total     (total),
        .clr_total (clr_total),
        .busy      (busy)
    );

    ones_count_stream #(.WIDTH(WIDTH), .CHUNK(CHUNK), .ACC_W(5)) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .data      (s_data),
        .out_valid (s_out_valid),
        .out_ready (1'b1),
        .count     (s_count),
        .total     (s_total),
        .clr_total (1'b0),
        .busy      (s_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_latency(input logic [WIDTH-1:0] d);
`ifdef ONES_COUNT_EARLY_EN
        int hi = 0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (((d >> (k * CHUNK)) & ((1 << CHUNK) - 1)) != 0) hi = k;
        end
        return hi + 1;
`else
        return NCHUNK;
`endif
    endfunction

    function automatic int sat_add(input int a, input int b, input int lim);
        return (a + b > lim) ? lim : a + b;
    endfunction

    // Called at a falling edge with the DUT idle.
    task automatic run_word(input logic [WIDTH-1:0] d, input int hold, input bit clr_at_done);
        int lat, pc, c;
        bit seen;
        lat = exp_latency(d);
        pc  = $countones(d);
        c = 0;
        while (!in_ready && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        data     = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        data     = WIDTH'($urandom);
        @(negedge clk);
        c = 0;
        seen = 1'b0;
        while (!seen && c < NCHUNK + 4) begin
            if (out_valid) begin
                seen = 1'b1;
            end else begin
                chk("busy", busy, 1);
                if (clr_at_done && c == lat - 1) clr_total = 1'b1;
                @(posedge clk); #1;
                clr_total = 1'b0;
                c++;
                @(negedge clk);
            end
        end
        chk("latency", c, lat);
        chk("out_valid", out_valid, 1);
        ref_total = clr_at_done ? pc : sat_add(ref_total, pc, TOT_MAX);
        chk("count", count, pc);
        chk("total", total, ref_total);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            data     = WIDTH'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_count", count, pc);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_total", total, ref_total);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("back_idle_ready", in_ready, 1);
        chk("back_idle_valid", out_valid, 0);
    endtask

    task automatic clr_idle();
        clr_total = 1'b1;
        @(posedge clk); #1;
        clr_total = 1'b0;
        @(negedge clk);
        ref_total = 0;
        chk("clr_idle", total, 0);
    endtask

    initial begin
        int c, s_exp;
        logic [WIDTH-1:0] d;
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; clr_total = 1'b0; data = '0;
        s_in_valid = 1'b0; s_data = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", count, 0);
        chk("rst_total", total, 0);

        run_word(16'h0001, 0, 1'b0);
        run_word(16'h0100, 0, 1'b0);
        run_word(16'h7FFF, 0, 1'b0);
        run_word(16'hFFFF, 0, 1'b0);
        chk("seq_total33", total, 33);
        run_word(16'h0000, 0, 1'b0);
        chk("zero_total", total, 33);

        clr_idle();
        run_word(16'h00FF, 10, 1'b0);
        chk("stall_total8", total, 8);

        s_exp = 0;
        for (int k = 0; k < 3; k++) begin
            s_in_valid = 1'b1;
            s_data     = 16'hFFFF;
            @(posedge clk); #1;
            s_in_valid = 1'b0;
            c = 0;
            @(negedge clk);
            while (!s_out_valid && c < 12) begin
                @(negedge clk);
                c++;
            end
            s_exp = sat_add(s_exp, 16, 31);
            chk("sat_count", s_count, 16);
            chk("sat_total", s_total, s_exp);
            @(negedge clk);
        end

        clr_idle();
        run_word(16'hFFFF, 0, 1'b0);
        run_word(16'h000F, 0, 1'b0);
        chk("pre_clr_total20", total, 20);
        run_word(16'h000F, 0, 1'b1);
        chk("clr_done_total4", total, 4);
        clr_idle();

        for (int n = 0; n < 30; n++) begin
            d = WIDTH'($urandom);
            for (int k = 0; k < NCHUNK; k++) begin
                if ($urandom_range(0, 1) == 1) d = d & ~(WIDTH'((1 << CHUNK) - 1) << (k * CHUNK));
            end
            run_word(d, $urandom_range(0, 2), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 9) == 0) clr_idle();
        end

        in_valid = 1'b1;
        data     = 16'hFFFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        chk("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_count", count, 0);
        chk("abort_total", total, 0);
        chk("abort_in_ready", in_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ref_total = 0;
        @(negedge clk);
        chk("abort_release_ready", in_ready, 1);
        for (int i = 0; i < NCHUNK + 2; i++) begin
            @(negedge clk);
            chk("abort_no_valid", out_valid, 0);
        end
        run_word(16'h0F0F, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
